// File: rtl/lock_pkg.sv
// Shared definitions for the keypad scanner and the lock decider.
// Holds the key code map and the one-hot scanner state encoding.
package lock_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0    = 4'b0000;
  localparam key_code_t KEY_1    = 4'b0001;
  localparam key_code_t KEY_2    = 4'b0010;
  localparam key_code_t KEY_3    = 4'b0011;
  localparam key_code_t KEY_4    = 4'b0100;
  localparam key_code_t KEY_5    = 4'b0101;
  localparam key_code_t KEY_6    = 4'b0110;
  localparam key_code_t KEY_7    = 4'b0111;
  localparam key_code_t KEY_8    = 4'b1000;
  localparam key_code_t KEY_9    = 4'b1001;
  localparam key_code_t KEY_STAR = 4'b1010;
  localparam key_code_t KEY_HASH = 4'b1011;

  localparam logic [3:0] SCAN     = 4'b0001;
  localparam logic [3:0] DEBOUNCE = 4'b0010;
  localparam logic [3:0] HOLD     = 4'b0100;
  localparam logic [3:0] RELEASE  = 4'b1000;

  // Physical layout: r0 = 1 2 3, r1 = 4 5 6, r2 = 7 8 9, r3 = * 0 #
  function automatic key_code_t key_code(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hC:    code = KEY_STAR;
      4'hD:    code = KEY_0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones
// so idle pulled-up lines read as inactive.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce, one event per press.
// SCAN: rotate columns | DEBOUNCE: confirm press | HOLD: wait for release | RELEASE: confirm release
module keypad_scanner
  import lock_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       key_down,
  output logic       multi_key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rows_s;
  logic [3:0]    state;
  logic [1:0]    col_idx;
  logic [1:0]    row_lat;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] db_cnt;
  logic          fire;

  logic [3:0] low;
  logic       none_low;
  logic       one_low;
  logic [1:0] low_row;
  logic       match_pat;
  logic [1:0] next_col;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset_1),
    .d     (row_n),
    .q     (rows_s)
  );

  assign low       = ~rows_s;
  assign none_low  = (low == 4'b0000);
  assign one_low   = !none_low && ((low & (low - 4'd1)) == 4'b0000);
  assign match_pat = (rows_s == ~(4'b0001 << row_lat));
  assign next_col  = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

  always_comb begin
    low_row = 2'd0;
    case (low)
      4'b0001: low_row = 2'd0;
      4'b0010: low_row = 2'd1;
      4'b0100: low_row = 2'd2;
      4'b1000: low_row = 2'd3;
      default: low_row = 2'd0;
    endcase
  end

  always_comb begin
    col_n = 3'b110;
    case (col_idx)
      2'd0:    col_n = 3'b110;
      2'd1:    col_n = 3'b101;
      2'd2:    col_n = 3'b011;
      default: col_n = 3'b110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_1) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      fire      <= 1'b0;
      Code_1    <= KEY_0;
      Valid_1   <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      Valid_1   <= 1'b0;
      multi_key <= 1'b0;
      fire      <= 1'b0;

      // The accepted press is published one clock after the last stable match.
      if (fire) begin
        Valid_1  <= 1'b1;
        Code_1   <= key_code(row_lat, col_idx);
        key_down <= 1'b1;
      end

      case (state)
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (none_low) begin
              col_idx <= next_col;
            end else if (one_low) begin
              row_lat <= low_row;
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              multi_key <= 1'b1;
              col_idx   <= next_col;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!match_pat) begin
            state     <= SCAN;
            col_idx   <= next_col;
            dwell_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            fire  <= 1'b1;
            state <= HOLD;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (none_low) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end

        RELEASE: begin
          if (!none_low) begin
            db_cnt <= '0;
            state  <= HOLD;
          end else if (db_cnt == DB_LAST) begin
            key_down  <= 1'b0;
            col_idx   <= 2'd0;
            dwell_cnt <= '0;
            state     <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state     <= SCAN;
          col_idx   <= 2'd0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A behavioural keypad pulls a row low while its key is pressed and its column is driven.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       key_down;
  logic       multi_key;

  logic [11:0] pressed = '0;  // bit r*3+c
  int cyc = 0;
  int r0 = 0;
  int tests = 0;
  int fails = 0;
  int both_err = 0;
  logic [3:0] vq[$];
  int vt[$];
  int mt[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset_1   (reset_1),
    .row_n     (row_n),
    .col_n     (col_n),
    .Code_1    (Code_1),
    .Valid_1   (Valid_1),
    .key_down  (key_down),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (Valid_1 === 1'b1) begin
      vq.push_back(Code_1);
      vt.push_back(cyc);
    end
    if (multi_key === 1'b1) mt.push_back(cyc);
    if (Valid_1 === 1'b1 && multi_key === 1'b1) both_err++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  // r0 is the index of the last clock edge that sampled reset high.
  task automatic do_reset();
    reset_1 = 1'b1;
    pressed = '0;
    step();
    step();
    reset_1 = 1'b0;
    r0 = cyc;
    vq.delete();
    vt.delete();
    mt.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (col_n !== 3'b110 || Code_1 !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: col_n=%b Code_1=%b, expected 110 0000", col_n, Code_1);
    end
    tests++;
    if (Valid_1 !== 1'b0 || key_down !== 1'b0 || multi_key !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: Valid_1=%b key_down=%b multi_key=%b, expected 0 0 0",
               Valid_1, key_down, multi_key);
    end
  endtask

  // Key 5: col1 driven at r0+4, sampled at r0+8, Valid at r0+8+9.
  task automatic test_key5();
    int e;
    do_reset();
    pressed[4] = 1'b1;
    run_to(r0 + 8);
    tests++;
    if (col_n !== 3'b101) begin
      fails++;
      $display("FAIL key5_col_freeze: col_n=%b, expected 101", col_n);
    end
    run_to(r0 + 16);
    tests++;
    if (vq.size() != 0) begin
      fails++;
      $display("FAIL key5_early_valid: %0d pulses, expected 0", vq.size());
    end
    run_to(r0 + 17);
    tests++;
    if (vq.size() != 1 || Valid_1 !== 1'b1 || Code_1 !== 4'b0101 || key_down !== 1'b1) begin
      fails++;
      $display("FAIL key5_valid: pulses=%0d Valid_1=%b Code_1=%b key_down=%b, expected 1 1 0101 1",
               vq.size(), Valid_1, Code_1, key_down);
    end
    run_to(r0 + 57);
    tests++;
    if (vq.size() != 1 || key_down !== 1'b1 || col_n !== 3'b101) begin
      fails++;
      $display("FAIL key5_no_repeat: pulses=%0d key_down=%b col_n=%b, expected 1 1 101",
               vq.size(), key_down, col_n);
    end
    pressed[4] = 1'b0;
    e = cyc;
    // 2 sync clocks + 1 to enter RELEASE + 8 stable clocks
    run_to(e + 10);
    tests++;
    if (key_down !== 1'b1) begin
      fails++;
      $display("FAIL key5_release_early: key_down=%b, expected 1", key_down);
    end
    run_to(e + 11);
    tests++;
    if (key_down !== 1'b0 || col_n !== 3'b110 || Code_1 !== 4'b0101) begin
      fails++;
      $display("FAIL key5_release: key_down=%b col_n=%b Code_1=%b, expected 0 110 0101",
               key_down, col_n, Code_1);
    end
  endtask

  // '#': col2 sampled at r0+12; bounce aborts DEBOUNCE at r0+16, rescan samples c2 at r0+28.
  task automatic test_bounce_hash();
    int b;
    do_reset();
    pressed[11] = 1'b1;
    run_to(r0 + 13);
    pressed[11] = 1'b0;
    step();
    pressed[11] = 1'b1;
    step();
    pressed[11] = 1'b0;
    step();
    pressed[11] = 1'b1;
    tests++;
    if (col_n !== 3'b110) begin
      fails++;
      $display("FAIL hash_abort: col_n=%b, expected 110", col_n);
    end
    run_to(r0 + 36);
    tests++;
    if (vq.size() != 0) begin
      fails++;
      $display("FAIL hash_early_valid: %0d pulses, expected 0", vq.size());
    end
    run_to(r0 + 37);
    tests++;
    if (vq.size() != 1 || Valid_1 !== 1'b1 || Code_1 !== 4'b1011) begin
      fails++;
      $display("FAIL hash_valid: pulses=%0d Valid_1=%b Code_1=%b, expected 1 1 1011",
               vq.size(), Valid_1, Code_1);
    end
    pressed[11] = 1'b0;
    b = 0;
    while (key_down !== 1'b0 && b < 100) begin step(); b++; end
    tests++;
    if (key_down !== 1'b0 || vq.size() != 1) begin
      fails++;
      $display("FAIL hash_release: key_down=%b pulses=%0d, expected 0 1", key_down, vq.size());
    end
  endtask

  // Keys 1 and 4 together: c0 samples at r0+4, r0+16, r0+28.
  task automatic test_multi();
    do_reset();
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    run_to(r0 + 30);
    tests++;
    if (mt.size() != 3) begin
      fails++;
      $display("FAIL multi_count: %0d pulses, expected 3", mt.size());
    end else if (mt[0] != r0 + 4 || mt[1] != r0 + 16 || mt[2] != r0 + 28) begin
      fails++;
      $display("FAIL multi_timing: at +%0d +%0d +%0d, expected +4 +16 +28",
               mt[0] - r0, mt[1] - r0, mt[2] - r0);
    end
    tests++;
    if (vq.size() != 0 || col_n !== 3'b101 || key_down !== 1'b0) begin
      fails++;
      $display("FAIL multi_no_valid: pulses=%0d col_n=%b key_down=%b, expected 0 101 0",
               vq.size(), col_n, key_down);
    end
    pressed = '0;
    step();
  endtask

  // '*': Valid at r0+13; short release then re-press keeps key_down high.
  task automatic test_star_repress();
    int e;
    int f;
    bit kd_lost;
    do_reset();
    pressed[9] = 1'b1;
    run_to(r0 + 13);
    tests++;
    if (vq.size() != 1 || Code_1 !== 4'b1010) begin
      fails++;
      $display("FAIL star_valid: pulses=%0d Code_1=%b, expected 1 1010", vq.size(), Code_1);
    end
    kd_lost = 1'b0;
    while (cyc < r0 + 20) begin step(); if (key_down !== 1'b1) kd_lost = 1'b1; end
    pressed[9] = 1'b0;
    e = cyc;
    while (cyc < e + 5) begin step(); if (key_down !== 1'b1) kd_lost = 1'b1; end
    pressed[9] = 1'b1;
    while (cyc < e + 15) begin step(); if (key_down !== 1'b1) kd_lost = 1'b1; end
    pressed[9] = 1'b0;
    f = cyc;
    while (cyc < f + 10) begin step(); if (key_down !== 1'b1) kd_lost = 1'b1; end
    tests++;
    if (kd_lost) begin
      fails++;
      $display("FAIL star_key_down_held: key_down dropped, expected held high");
    end
    run_to(f + 11);
    tests++;
    if (key_down !== 1'b0 || vq.size() != 1 || Code_1 !== 4'b1010) begin
      fails++;
      $display("FAIL star_final: key_down=%b pulses=%0d Code_1=%b, expected 0 1 1010",
               key_down, vq.size(), Code_1);
    end
  endtask

  // Key 0: reset on the clock that would take the debounce count from 6 to 7.
  task automatic test_reset_midway();
    int r1;
    do_reset();
    pressed[10] = 1'b1;
    run_to(r0 + 14);
    reset_1 = 1'b1;
    step();
    reset_1 = 1'b0;
    r1 = cyc;
    tests++;
    if (col_n !== 3'b110 || Code_1 !== 4'b0000 || key_down !== 1'b0 || vq.size() != 0) begin
      fails++;
      $display("FAIL midreset_state: col_n=%b Code_1=%b key_down=%b pulses=%0d, expected 110 0000 0 0",
               col_n, Code_1, key_down, vq.size());
    end
    run_to(r1 + 16);
    tests++;
    if (vq.size() != 0) begin
      fails++;
      $display("FAIL midreset_no_valid: %0d pulses, expected 0", vq.size());
    end
    run_to(r1 + 17);
    tests++;
    if (vq.size() != 1 || Valid_1 !== 1'b1 || Code_1 !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_redetect: pulses=%0d Valid_1=%b Code_1=%b, expected 1 1 0000",
               vq.size(), Valid_1, Code_1);
    end
    pressed = '0;
    step();
  endtask

  task automatic test_back_to_back();
    int keys [5] = '{0, 1, 2, 3, 11};
    logic [3:0] codes [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1011};
    int b;
    bit order_bad;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pressed[keys[k]] = 1'b1;
      b = 0;
      while (vq.size() < k + 1 && b < 200) begin step(); b++; end
      tests++;
      if (vq.size() != k + 1 || Code_1 !== codes[k]) begin
        fails++;
        $display("FAIL seq_valid_%0d: pulses=%0d Code_1=%b, expected %0d %b",
                 k, vq.size(), Code_1, k + 1, codes[k]);
      end
      pressed[keys[k]] = 1'b0;
      b = 0;
      while (key_down !== 1'b0 && b < 200) begin step(); b++; end
      repeat (5) step();
      tests++;
      if (Code_1 !== codes[k] || key_down !== 1'b0) begin
        fails++;
        $display("FAIL seq_hold_%0d: Code_1=%b key_down=%b, expected %b 0",
                 k, Code_1, key_down, codes[k]);
      end
    end
    order_bad = (vq.size() != 5);
    if (!order_bad)
      for (int k = 0; k < 5; k++) if (vq[k] !== codes[k]) order_bad = 1'b1;
    tests++;
    if (order_bad) begin
      fails++;
      $display("FAIL seq_order: %0d pulses captured, expected 1 2 3 4 # in order", vq.size());
    end
  endtask

  initial begin
    reset_1 = 1'b1;
    test_reset();
    test_key5();
    test_bounce_hash();
    test_multi();
    test_star_repress();
    test_reset_midway();
    test_back_to_back();
    tests++;
    if (both_err != 0) begin
      fails++;
      $display("FAIL valid_multi_overlap: %0d cycles, expected 0", both_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
